// File: rtl/device_regs_ctrl_pkg.sv
// Types, constants and the address decoder for the device register block.
// No logic of its own; pure declarations plus one combinational helper.
// Not applicable: no handshake lives here.
`include "device_regs_defs.vh"

package device_regs_ctrl_pkg;

    localparam int          DATA_W   = 8;
    localparam int          ADDR_W   = 4;
    localparam int          NUM_REGS = 4;
    localparam int          STATUS_W = 3;
    localparam logic [7:0]  ID_VALUE = 8'hC3;

    // Implemented CTRL bits; bits 7:2 of the data word have no storage.
    typedef struct packed {
        logic irq_en;
        logic cnt_en;
    } ctrl_t;

    // Which register an address selects.
    typedef enum logic [2:0] {
        SEL_REG    = 3'd0,
        SEL_CTRL   = 3'd1,
        SEL_COUNT  = 3'd2,
        SEL_STATUS = 3'd3,
        SEL_ID     = 3'd4,
        SEL_NONE   = 3'd5
    } sel_e;

    function automatic sel_e decode_addr(input logic [ADDR_W-1:0] addr);
        sel_e sel;
        case (addr)
            `REG0_OFFSET, `REG1_OFFSET,
            `REG2_OFFSET, `REG3_OFFSET: sel = SEL_REG;
            `CTRL_OFFSET:               sel = SEL_CTRL;
            `COUNT_OFFSET:              sel = SEL_COUNT;
            `STATUS_OFFSET:             sel = SEL_STATUS;
            `ID_OFFSET:                 sel = SEL_ID;
            default:                    sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/device_regs_ctrl_if.sv
// Register access bus between an initiator and the register block.
// Strobes are single-cycle; read data returns one cycle after read_en.
// No backpressure: the responder accepts every strobe with zero wait states.
interface device_regs_ctrl_if;
    import device_regs_ctrl_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              write_en;
    logic              read_en;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] read_data;

    modport master (
        output address,
        output write_en,
        output read_en,
        output data_in,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_en,
        input  read_en,
        input  data_in,
        output read_data
    );
endinterface

// File: rtl/device_regs_defs.vh
// Register offsets and bit positions shared by the register block and its users.
// Offsets are 4-bit register addresses; bit positions index the 8-bit data word.
// Guarded so it can be pulled into several compilation units safely.
`ifndef DEVICE_REGS_DEFS_VH
`define DEVICE_REGS_DEFS_VH

`define REG0_OFFSET   4'h0
`define REG1_OFFSET   4'h1
`define REG2_OFFSET   4'h2
`define REG3_OFFSET   4'h3
`define CTRL_OFFSET   4'h4
`define COUNT_OFFSET  4'h5
`define STATUS_OFFSET 4'h6
`define ID_OFFSET     4'h7

// CTRL bit positions
`define CTRL_CNT_EN_BIT 0
`define CTRL_IRQ_EN_BIT 1

// STATUS bit positions
`define STATUS_WRAP_BIT   0
`define STATUS_WR_ERR_BIT 1
`define STATUS_RD_ERR_BIT 2

`endif

// File: rtl/reg_counter8.sv
// Free-running 8-bit counter with enable and a wrap indication.
// Count updates on the enabled edge; wrap_o is high in the cycle whose edge rolls FF->00.
// No backpressure: counts every enabled cycle.
module reg_counter8
    import device_regs_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              resetb,
    input  logic              en_i,
    output logic [DATA_W-1:0] count_o,
    output logic              wrap_o
);

    logic [DATA_W-1:0] count_q;
    logic [DATA_W-1:0] count_d;

    // Next count: increment while enabled, natural 8-bit rollover.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Wrap is combinational from the flop so the sticky status bit and the
    // rollover land on the same clock edge.
    assign wrap_o  = en_i && (count_q == 8'hFF);
    assign count_o = count_q;

endmodule

// File: rtl/device_regs_ctrl.sv
// Register-file responder: scratch regs, CTRL, COUNT, W1C STATUS, ID, plus a level irq.
// Writes commit on the strobe edge; read_data is registered, valid one cycle after read_en.
// No backpressure or wait states; back-to-back strobes are accepted every cycle.
`include "device_regs_defs.vh"

module device_regs_ctrl
    import device_regs_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               resetb,
    device_regs_ctrl_if.slave  bus,
    output logic               irq
);

    sel_e                             sel;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs_d;
    ctrl_t                            ctrl_q;
    ctrl_t                            ctrl_d;
    logic [STATUS_W-1:0]              status_q;
    logic [STATUS_W-1:0]              status_d;
    logic [STATUS_W-1:0]              status_set;
    logic [STATUS_W-1:0]              status_clr;
    logic [DATA_W-1:0]                rd_val;
    logic [DATA_W-1:0]                read_data_q;
    logic [DATA_W-1:0]                read_data_d;
    logic [DATA_W-1:0]                count;
    logic                             cnt_wrap;

    assign sel = decode_addr(bus.address);

    reg_counter8 u_counter (
        .clk     (clk),
        .resetb  (resetb),
        .en_i    (ctrl_q.cnt_en),
        .count_o (count),
        .wrap_o  (cnt_wrap)
    );

    // Write path for the plain RW registers; COUNT and ID ignore writes.
    always_comb begin
        regs_d = regs_q;
        ctrl_d = ctrl_q;
        if (bus.write_en) begin
            case (sel)
                SEL_REG: regs_d[bus.address[1:0]] = bus.data_in;
                SEL_CTRL: begin
                    ctrl_d.cnt_en = bus.data_in[`CTRL_CNT_EN_BIT];
                    ctrl_d.irq_en = bus.data_in[`CTRL_IRQ_EN_BIT];
                end
                default: ;
            endcase
        end
    end

    // Sticky status: W1C clear first, then set events, so a same-edge set wins.
    always_comb begin
        status_set = '0;
        status_clr = '0;
        status_set[`STATUS_WRAP_BIT]   = cnt_wrap;
        status_set[`STATUS_WR_ERR_BIT] = bus.write_en && (sel == SEL_NONE);
        status_set[`STATUS_RD_ERR_BIT] = bus.read_en  && (sel == SEL_NONE);
        if (bus.write_en && (sel == SEL_STATUS)) begin
            status_clr = bus.data_in[STATUS_W-1:0];
        end
        status_d = (status_q & ~status_clr) | status_set;
    end

    // Read mux samples pre-edge flop values, so a same-cycle write reads old data.
    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_REG: rd_val = regs_q[bus.address[1:0]];
            SEL_CTRL: begin
                rd_val[`CTRL_CNT_EN_BIT] = ctrl_q.cnt_en;
                rd_val[`CTRL_IRQ_EN_BIT] = ctrl_q.irq_en;
            end
            SEL_COUNT:  rd_val = count;
            SEL_STATUS: rd_val[STATUS_W-1:0] = status_q;
            SEL_ID:     rd_val = ID_VALUE;
            default:    rd_val = '0;
        endcase
        read_data_d = bus.read_en ? rd_val : read_data_q;
    end

    // State registers; everything except ID returns to zero on reset.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            regs_q      <= '0;
            ctrl_q      <= '0;
            status_q    <= '0;
            read_data_q <= '0;
        end else begin
            regs_q      <= regs_d;
            ctrl_q      <= ctrl_d;
            status_q    <= status_d;
            read_data_q <= read_data_d;
        end
    end

    assign bus.read_data = read_data_q;
    assign irq           = ctrl_q.irq_en && (|status_q);

endmodule

// File: tb/tb_device_regs_ctrl.sv
// Directed bench for device_regs_ctrl: table of bus operations with expected results,
// plus a hand-written reset-during-write sequence.
module tb_device_regs_ctrl;

    localparam logic [1:0] OP_WR   = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_RW   = 2'd2;
    localparam logic [1:0] OP_IDLE = 2'd3;

    typedef struct {
        logic [1:0] op;
        logic [3:0] addr;
        logic [7:0] wdat;
        int         n;
        logic       chk_rd;
        logic [7:0] exp_rd;
        logic       chk_irq;
        logic       exp_irq;
    } vec_t;

    logic clk;
    logic resetb;
    logic irq;
    int   n_checks;
    int   n_fails;
    vec_t vecs[$];
    vec_t post[$];

    device_regs_ctrl_if bus_if ();

    device_regs_ctrl dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus_if),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] op, input logic [3:0] addr,
                                input logic [7:0] wdat, input int n,
                                input logic chk_rd, input logic [7:0] exp_rd,
                                input logic chk_irq, input logic exp_irq);
        vec_t v;
        v.op = op; v.addr = addr; v.wdat = wdat; v.n = n;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        v.chk_irq = chk_irq; v.exp_irq = exp_irq;
        return v;
    endfunction

    function automatic vec_t wr(input logic [3:0] a, input logic [7:0] d,
                                input logic ci, input logic ei);
        return mk(OP_WR, a, d, 0, 1'b0, 8'h00, ci, ei);
    endfunction

    function automatic vec_t rd(input logic [3:0] a, input logic [7:0] e,
                                input logic ci, input logic ei);
        return mk(OP_RD, a, 8'h00, 0, 1'b1, e, ci, ei);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Each operation is driven at a falling edge and spans exactly one rising edge.
    task automatic apply(input vec_t v, input string tag);
        case (v.op)
            OP_WR: begin
                bus_if.address  = v.addr;
                bus_if.data_in  = v.wdat;
                bus_if.write_en = 1'b1;
                @(negedge clk);
            end
            OP_RD: begin
                bus_if.address = v.addr;
                bus_if.read_en = 1'b1;
                @(negedge clk);
            end
            OP_RW: begin
                bus_if.address  = v.addr;
                bus_if.data_in  = v.wdat;
                bus_if.write_en = 1'b1;
                bus_if.read_en  = 1'b1;
                @(negedge clk);
            end
            default: repeat (v.n) @(negedge clk);
        endcase
        bus_if.write_en = 1'b0;
        bus_if.read_en  = 1'b0;
        bus_if.address  = 4'hF;
        bus_if.data_in  = 8'h00;
        if (v.chk_rd)  check({tag, " read_data"}, bus_if.read_data, v.exp_rd);
        if (v.chk_irq) check({tag, " irq"}, {7'b0, irq}, {7'b0, v.exp_irq});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;

        // E0 denotes the edge of the first CTRL write; COUNT after edge E0+k is k mod 256.
        vecs.push_back(wr(4'h0, 8'hA5, 0, 0));
        vecs.push_back(wr(4'h1, 8'hA6, 0, 0));
        vecs.push_back(wr(4'h2, 8'hA7, 0, 0));
        vecs.push_back(wr(4'h3, 8'hA8, 0, 0));
        vecs.push_back(rd(4'h0, 8'hA5, 0, 0));
        vecs.push_back(rd(4'h1, 8'hA6, 0, 0));
        vecs.push_back(rd(4'h2, 8'hA7, 0, 0));
        vecs.push_back(rd(4'h3, 8'hA8, 0, 0));
        vecs.push_back(rd(4'h7, 8'hC3, 0, 0));
        vecs.push_back(rd(4'h5, 8'h00, 1, 0));                       // counter idle
        vecs.push_back(wr(4'h4, 8'h05, 0, 0));                       // E0
        vecs.push_back(rd(4'h4, 8'h01, 0, 0));                       // E0+1
        vecs.push_back(mk(OP_IDLE, 4'hF, 8'h00, 255, 0, 8'h00, 1, 0)); // to E0+256: wrap
        vecs.push_back(rd(4'h6, 8'h01, 1, 0));                       // E0+257
        vecs.push_back(rd(4'h5, 8'h01, 0, 0));                       // E0+258
        vecs.push_back(wr(4'h4, 8'h03, 1, 1));                       // E0+259
        vecs.push_back(wr(4'h6, 8'h01, 1, 0));                       // E0+260
        vecs.push_back(rd(4'h6, 8'h00, 0, 0));                       // E0+261
        vecs.push_back(mk(OP_IDLE, 4'hF, 8'h00, 249, 0, 8'h00, 1, 0)); // to E0+510
        vecs.push_back(rd(4'h5, 8'hFE, 0, 0));                       // E0+511
        vecs.push_back(wr(4'h6, 8'h01, 1, 1));                       // E0+512: clear on wrap edge
        vecs.push_back(rd(4'h6, 8'h01, 0, 0));
        vecs.push_back(wr(4'h6, 8'h01, 1, 0));
        vecs.push_back(wr(4'h4, 8'h02, 1, 0));                       // E0+515: count stops at 3
        vecs.push_back(rd(4'h4, 8'h02, 0, 0));
        vecs.push_back(rd(4'h9, 8'h00, 1, 1));
        vecs.push_back(rd(4'h6, 8'h04, 0, 0));
        vecs.push_back(wr(4'hC, 8'h55, 1, 1));
        vecs.push_back(rd(4'h6, 8'h06, 0, 0));
        vecs.push_back(rd(4'h0, 8'hA5, 0, 0));
        vecs.push_back(rd(4'h1, 8'hA6, 0, 0));
        vecs.push_back(rd(4'h2, 8'hA7, 0, 0));
        vecs.push_back(rd(4'h3, 8'hA8, 0, 0));
        vecs.push_back(mk(OP_RW, 4'h2, 8'h3C, 0, 1, 8'hA7, 0, 0));   // read sees old value
        vecs.push_back(rd(4'h2, 8'h3C, 0, 0));
        vecs.push_back(mk(OP_IDLE, 4'hF, 8'h00, 3, 1, 8'h3C, 0, 0)); // read_data holds
        vecs.push_back(wr(4'h6, 8'h07, 1, 0));
        vecs.push_back(mk(OP_IDLE, 4'hF, 8'h00, 2, 0, 8'h00, 0, 0));
        vecs.push_back(wr(4'h5, 8'h77, 1, 0));                       // COUNT write ignored, no error
        vecs.push_back(rd(4'h6, 8'h00, 0, 0));
        vecs.push_back(rd(4'h5, 8'h03, 0, 0));
        vecs.push_back(wr(4'h4, 8'hF2, 0, 0));
        vecs.push_back(rd(4'h4, 8'h02, 0, 0));
        vecs.push_back(rd(4'h9, 8'h00, 1, 1));
        vecs.push_back(rd(4'h7, 8'hC3, 0, 0));

        // After reset: everything zero, ID intact, the interrupted write lost.
        post.push_back(rd(4'h0, 8'h00, 1, 0));
        post.push_back(rd(4'h1, 8'h00, 0, 0));
        post.push_back(rd(4'h2, 8'h00, 0, 0));
        post.push_back(rd(4'h3, 8'h00, 0, 0));
        post.push_back(rd(4'h4, 8'h00, 0, 0));
        post.push_back(rd(4'h5, 8'h00, 0, 0));
        post.push_back(rd(4'h6, 8'h00, 0, 0));
        post.push_back(rd(4'h7, 8'hC3, 1, 0));

        resetb          = 1'b0;
        bus_if.address  = 4'hF;
        bus_if.write_en = 1'b0;
        bus_if.read_en  = 1'b0;
        bus_if.data_in  = 8'h00;
        repeat (2) @(negedge clk);
        check("reset read_data", bus_if.read_data, 8'h00);
        check("reset irq", {7'b0, irq}, 8'h00);
        resetb = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted in the middle of a write strobe.
        check("pre-reset irq", {7'b0, irq}, 8'h01);
        bus_if.address  = 4'h0;
        bus_if.data_in  = 8'hFF;
        bus_if.write_en = 1'b1;
        #2;
        resetb = 1'b0;
        #1;
        check("async reset read_data", bus_if.read_data, 8'h00);
        check("async reset irq", {7'b0, irq}, 8'h00);
        @(negedge clk);
        bus_if.write_en = 1'b0;
        bus_if.address  = 4'hF;
        bus_if.data_in  = 8'h00;
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);

        for (int i = 0; i < post.size(); i++) begin
            apply(post[i], $sformatf("post%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/device_regs_ctrl.md
# device_regs_ctrl

Register-file responder for the 4-bit-address / 8-bit-data register access interface. The initiator presents an address, then pulses `write_en` or `read_en` for one cycle. The block holds four scratch registers, a control register, a free-running counter, W1C status and a constant ID. It sits behind the initiator as the addressable device and raises a level interrupt from sticky status.

## Interface
- `ID_VALUE`, 8'hC3, constant returned at offset 0x7
- `clk`  in  1  single clock, rising-edge
- `resetb`  in  1  asynchronous, active-low reset
- `address`  in  4  register offset; 4'hF is the idle value between accesses
- `write_en`  in  1  one-cycle write strobe; `data_in` is valid in the same cycle
- `read_en`  in  1  one-cycle read strobe
- `data_in`  in  8  write data
- `read_data`  out  8  registered read data, held until the next read
- `irq`  out  1  level interrupt: `CTRL.irq_en & |STATUS`

## Operation
- Register map:
  - 0x0–0x3 REG0–REG3: RW, reset 8'h00
  - 0x4 CTRL: RW. bit0 `cnt_en`, bit1 `irq_en`; bits 7:2 read 0 and writes to them are ignored. Reset 8'h00.
  - 0x5 COUNT: RO. Increments by 1 every clock while `cnt_en`=1 and wraps 8'hFF→8'h00. Writes are ignored and are not errors.
  - 0x6 STATUS: W1C. bit0 `wrap` (sticky, set on the FF→00 increment), bit1 `wr_err` (write to an unmapped offset), bit2 `rd_err` (read from an unmapped offset). Bits 7:3 read 0.
  - 0x7 ID: RO, `ID_VALUE`
  - 0x8–0xF: unmapped. Reads return 8'h00 and set `rd_err`. Writes are discarded and set `wr_err`.
- An access happens only on a cycle where the strobe is high. An idle address of 4'hF with both strobes low has no effect and sets no error.
- Write: at the rising edge where `write_en`=1, the target register is loaded from `data_in`.
- Read: at the rising edge where `read_en`=1, `read_data` is loaded with the current value at `address`.
- `write_en` and `read_en` high together:
  - The write commits.
  - The read returns the pre-write value.
- STATUS set/clear on the same edge: set has priority, so a bit that is set and W1C-cleared on the same edge remains 1.
- The COUNT wrap and the `wrap` status bit update on the same edge.
- `irq` is derived only from flop outputs. There is no combinational path from any input to `irq` or `read_data`.

## Timing
- Reset (async assert, release synchronous to `clk`):
  - all registers 8'h00 except ID
  - `read_data`=8'h00
  - `irq`=0
- Read latency is 1 cycle. `read_data` is valid after the edge that samples `read_en` and is stable by the following edge, where the initiator samples it. It holds indefinitely until the next read.
- A write is visible to a read strobed on the next cycle or later.
- After a W1C write, `irq` deasserts on the cycle after the write edge unless a bit is re-set on that same edge.
- Back-to-back strobes on consecutive cycles are legal. There are no wait states.
- Reset mid-access: the access is lost, and all state returns to its reset value immediately.

## Structure
- Shared include `device_regs_defs.vh`:
  - offsets REG0_OFFSET–REG3_OFFSET, CTRL_OFFSET=4'h4, COUNT_OFFSET=4'h5, STATUS_OFFSET=4'h6, ID_OFFSET=4'h7
  - CTRL bit positions
  - STATUS bit positions
- Sub-module `reg_counter8`: 8-bit counter with enable and a one-cycle `wrap` pulse.
- Decode, W1C logic and the read mux stay in the top module.

## Test plan
- Write 0xA5/0xA6/0xA7/0xA8 to 0x0–0x3, then read each back → `read_data` is 0xA5, 0xA6, 0xA7, 0xA8 one cycle after each `read_en`. Read 0x7 → 0xC3.
- Write 0x05 to CTRL (bit2 is unimplemented) and read it back → 0x01. Wait 256 cycles → STATUS reads 0x01 and `irq`=0. Write 0x03 to CTRL → `irq`=1.
- With `irq`=1, write 0x01 to STATUS → `irq` is 0 the next cycle and STATUS reads 0x00. With the count at 0xFF, W1C-clear on the wrap edge → `wrap` stays 1.
- Read 0x9 → 0x00, then STATUS reads 0x04. Write 0x55 to 0xC → STATUS reads 0x06 and REG0–REG3 are unchanged.
- Write 0x3C to REG2 with `read_en`=1 on the same cycle at 0x2, where REG2 previously held 0xA7 → `read_data`=0xA7, and the next read returns 0x3C.
- Assert `resetb`=0 during a write strobe → all registers, `read_data` and `irq` go to 0 asynchronously, and ID still reads 0xC3.
